// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle between a producer/consumer pair and fifo_sync_param.
// The bench or client logic takes the master side; the FIFO takes the slave side.
interface fifo_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wen;
  logic             ren;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] dout;
  logic             error;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             err_ovf;
  logic             err_udf;

  modport master (
    output wen, ren, din, err_clr,
    input  dout, error, full, empty, almost_full, almost_empty, count, err_ovf, err_udf
  );

  modport slave (
    input  wen, ren, din, err_clr,
    output dout, error, full, empty, almost_full, almost_empty, count, err_ovf, err_udf
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, a one-cycle error pulse and sticky overflow/underflow flags.

// One storage entry; deliberately not reset so it maps onto plain flops/RAM.
module fifo_sync_param_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module fifo_sync_param #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_sync_param_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic             wen;
    logic             ren;
    logic             clr;
    logic [WIDTH-1:0] din;
  } req_t;

  req_t                         req;
  logic [AW-1:0]                wptr, rptr;
  logic [AW:0]                  cnt;
  logic [WIDTH-1:0]             dout_q;
  logic                         error_q, ovf_q, udf_q;
  logic                         full, empty;
  logic                         wr_ok, rd_ok, ovf_hit, udf_hit;
  logic [DEPTH-1:0]             cell_we;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q;

  assign req = '{wen: bus.wen, ren: bus.ren, clr: bus.err_clr, din: bus.din};

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

  // A read frees a slot in the same edge, so a write into a full FIFO is
  // legal whenever it is paired with a read.
  assign wr_ok   = req.wen & (~full | req.ren);
  assign rd_ok   = req.ren & ~empty;
  assign ovf_hit = req.wen & full & ~req.ren;
  assign udf_hit = req.ren & empty;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign cell_we[i] = wr_ok & (wptr == AW'(i));
    fifo_sync_param_cell #(.WIDTH(WIDTH)) u_cell (
      .clk (clk),
      .we  (cell_we[i]),
      .d   (req.din),
      .q   (mem_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      dout_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) begin
        rptr   <= rptr + AW'(1);
        dout_q <= mem_q[rptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      error_q <= ovf_hit | udf_hit;
    end
  end

  // Sticky flags: a fresh illegal request outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_hit)      ovf_q <= 1'b1;
      else if (req.clr) ovf_q <= 1'b0;
      if (udf_hit)      udf_q <= 1'b1;
      else if (req.clr) udf_q <= 1'b0;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.error        = error_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt >= (AW+1)'(AF_LVL));
  assign bus.almost_empty = (cnt <= (AW+1)'(AE_LVL));
  assign bus.count        = cnt;
  assign bus.err_ovf      = ovf_q;
  assign bus.err_udf      = udf_q;
endmodule
